// File: rtl/immediate_encoder.sv
// ----------------------------------------------------------------------------
// immediate_encoder
//   Packs a 32-bit immediate into the U/I/S/B/J bit positions of a RISC-V
//   instruction word. All other bits come from base_fields. The datapath is a
//   two-stage valid/ready pipeline:
//     S1 holds the accepted request; the encoding and range checks are
//        computed from it.
//     S2 is the output register.
//   A saturating counter tracks how many errored results have been emitted.
//
// Ports
//   clk              in   1          clock, rising edge
//   reset_n          in   1          synchronous active-low reset
//   in_valid         in   1          request valid
//   in_ready         out  1          request accepted when in_valid && in_ready
//   immediate_select in   3          000 U, 001 I, 010 S, 011 B, 100 J, else invalid
//   immediate_value  in   32         immediate, two's complement
//   base_fields      in   32         non-immediate instruction fields
//   out_valid        out  1          result valid
//   out_ready        in   1          result consumed when out_valid && out_ready
//   instruction_out  out  32         encoded instruction
//   range_error      out  1          immediate not representable in format
//   format_error     out  1          immediate_select is 101/110/111
//   error_count      out  ERR_CNT_W  saturating count of emitted errored results
// ----------------------------------------------------------------------------
module immediate_encoder #(
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           immediate_select,
    input  logic [31:0]          immediate_value,
    input  logic [31:0]          base_fields,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          instruction_out,
    output logic                 range_error,
    output logic                 format_error,
    output logic [ERR_CNT_W-1:0] error_count
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned SEL_W = 3;

    localparam logic [SEL_W-1:0] SEL_U = 3'b000;
    localparam logic [SEL_W-1:0] SEL_I = 3'b001;
    localparam logic [SEL_W-1:0] SEL_S = 3'b010;
    localparam logic [SEL_W-1:0] SEL_B = 3'b011;
    localparam logic [SEL_W-1:0] SEL_J = 3'b100;

    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    // Request payload held in S1
    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  base;
    } req_t;

    // Result payload held in S2
    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic            range_err;
        logic            format_err;
    } rsp_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic                 s1_valid_q, s1_valid_d;
    req_t                 s1_req_q,   s1_req_d;
    logic                 s2_valid_q, s2_valid_d;
    rsp_t                 s2_rsp_q,   s2_rsp_d;
    logic [ERR_CNT_W-1:0] err_cnt_q,  err_cnt_d;

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    logic s2_ready_c;
    logic s1_ready_c;
    logic in_fire_c;
    logic out_fire_c;

    assign s2_ready_c = !s2_valid_q || out_ready;
    assign s1_ready_c = !s1_valid_q || s2_ready_c;
    // Nothing is accepted in a cycle where reset is asserted.
    assign in_ready   = reset_n && s1_ready_c;
    assign in_fire_c  = in_valid && in_ready;
    assign out_fire_c = s2_valid_q && out_ready;

    // ------------------------------------------------------------------------
    // Range checks: the upper immediate bits must be a pure sign extension
    // ------------------------------------------------------------------------
    logic sext11_ok_c;
    logic sext12_ok_c;
    logic sext20_ok_c;

    assign sext11_ok_c = (&s1_req_q.imm[31:11]) || !(|s1_req_q.imm[31:11]);
    assign sext12_ok_c = (&s1_req_q.imm[31:12]) || !(|s1_req_q.imm[31:12]);
    assign sext20_ok_c = (&s1_req_q.imm[31:20]) || !(|s1_req_q.imm[31:20]);

    // ------------------------------------------------------------------------
    // Encoding of the S1 request. Truncated bits are still placed when the
    // range check fails; an invalid select passes base_fields through.
    // ------------------------------------------------------------------------
    rsp_t enc_c;

    always_comb begin
        enc_c            = '0;
        enc_c.inst       = s1_req_q.base;
        enc_c.range_err  = 1'b0;
        enc_c.format_err = 1'b0;
        case (s1_req_q.sel)
            SEL_U: begin
                enc_c.inst[31:12] = s1_req_q.imm[31:12];
                enc_c.range_err   = |s1_req_q.imm[11:0];
            end
            SEL_I: begin
                enc_c.inst[31:20] = s1_req_q.imm[11:0];
                enc_c.range_err   = !sext11_ok_c;
            end
            SEL_S: begin
                enc_c.inst[31:25] = s1_req_q.imm[11:5];
                enc_c.inst[11:7]  = s1_req_q.imm[4:0];
                enc_c.range_err   = !sext11_ok_c;
            end
            SEL_B: begin
                enc_c.inst[31]    = s1_req_q.imm[12];
                enc_c.inst[30:25] = s1_req_q.imm[10:5];
                enc_c.inst[11:8]  = s1_req_q.imm[4:1];
                enc_c.inst[7]     = s1_req_q.imm[11];
                enc_c.range_err   = s1_req_q.imm[0] || !sext12_ok_c;
            end
            SEL_J: begin
                enc_c.inst[31]    = s1_req_q.imm[20];
                enc_c.inst[30:21] = s1_req_q.imm[10:1];
                enc_c.inst[20]    = s1_req_q.imm[11];
                enc_c.inst[19:12] = s1_req_q.imm[19:12];
                enc_c.range_err   = s1_req_q.imm[0] || !sext20_ok_c;
            end
            default: begin
                enc_c.format_err  = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------------
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_req_d   = s1_req_q;
        s2_valid_d = s2_valid_q;
        s2_rsp_d   = s2_rsp_q;
        err_cnt_d  = err_cnt_q;

        // S1 refills from the input whenever it can move on.
        if (s1_ready_c) begin
            s1_valid_d = in_fire_c;
        end
        if (in_fire_c) begin
            s1_req_d.sel  = immediate_select;
            s1_req_d.imm  = immediate_value;
            s1_req_d.base = base_fields;
        end

        // S2 only loads when empty or being consumed; otherwise it holds.
        if (s2_ready_c) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_rsp_d = enc_c;
            end
        end

        // Count errored results as they leave, saturating at all-ones.
        if (out_fire_c && (s2_rsp_q.range_err || s2_rsp_q.format_err)
                && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_req_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_rsp_q   <= '0;
            err_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_req_q   <= s1_req_d;
            s2_valid_q <= s2_valid_d;
            s2_rsp_q   <= s2_rsp_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign out_valid       = s2_valid_q;
    assign instruction_out = s2_rsp_q.inst;
    assign range_error     = s2_rsp_q.range_err;
    assign format_error    = s2_rsp_q.format_err;
    assign error_count     = err_cnt_q;

endmodule

// File: tb/tb_immediate_encoder.sv
// ----------------------------------------------------------------------------
// tb_immediate_encoder
//   Directed and randomized checks of immediate_encoder against a reference
//   model that maps instruction bits to immediate bits through a lookup
//   function and judges range with signed arithmetic.
// ----------------------------------------------------------------------------
module tb_immediate_encoder;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  immediate_select;
    logic [31:0] immediate_value;
    logic [31:0] base_fields;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instruction_out;
    logic        range_error;
    logic        format_error;
    logic [7:0]  error_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] inst;
        logic        rng;
        logic        fmt;
    } exp_t;

    immediate_encoder #(.ERR_CNT_W(8)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .immediate_select (immediate_select),
        .immediate_value  (immediate_value),
        .base_fields      (base_fields),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .instruction_out  (instruction_out),
        .range_error      (range_error),
        .format_error     (format_error),
        .error_count      (error_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    // Which immediate bit lands in instruction bit pos, or -1 for base_fields.
    function automatic int imm_src(input logic [2:0] sel, input int pos);
        case (sel)
            3'd0: return (pos >= 12) ? pos : -1;
            3'd1: return (pos >= 20) ? pos - 20 : -1;
            3'd2: begin
                if (pos >= 25) return pos - 20;
                if (pos >= 7 && pos <= 11) return pos - 7;
                return -1;
            end
            3'd3: begin
                if (pos == 31) return 12;
                if (pos >= 25) return pos - 20;
                if (pos >= 8 && pos <= 11) return pos - 7;
                if (pos == 7) return 11;
                return -1;
            end
            3'd4: begin
                if (pos == 31) return 20;
                if (pos >= 21) return pos - 20;
                if (pos == 20) return 11;
                if (pos >= 12) return pos;
                return -1;
            end
            default: return -1;
        endcase
    endfunction

    function automatic exp_t model(input logic [2:0] sel, input logic [31:0] imm,
                                   input logic [31:0] base);
        exp_t   e;
        longint s;
        int     src;
        s     = longint'($signed(imm));
        e.inst = base;
        e.rng  = 1'b0;
        e.fmt  = 1'b0;
        if (sel > 3'd4) begin
            e.fmt = 1'b1;
            return e;
        end
        for (int p = 0; p < 32; p++) begin
            src = imm_src(sel, p);
            if (src >= 0) e.inst[p] = imm[src];
        end
        case (sel)
            3'd0:    e.rng = (imm % 32'd4096) != 0;
            3'd1,
            3'd2:    e.rng = (s < -2048) || (s > 2047);
            3'd3:    e.rng = (s % 2 != 0) || (s < -4096) || (s > 4095);
            default: e.rng = (s % 2 != 0) || (s < -(64'sd1 << 20)) || (s > (64'sd1 << 20) - 1);
        endcase
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] sel, input logic [31:0] imm,
                         input logic [31:0] base);
        in_valid         = v;
        immediate_select = sel;
        immediate_value  = imm;
        base_fields      = base;
    endtask

    // Sends one request with out_ready high; captures the result one edge
    // after acceptance plus one and lets it be consumed.
    task automatic send_one(input logic [2:0] sel, input logic [31:0] imm,
                            input logic [31:0] base, output exp_t got, output logic seen);
        out_ready = 1'b1;
        drive(1'b1, sel, imm, base);
        tick();
        in_valid = 1'b0;
        tick();
        seen     = out_valid;
        got.inst = instruction_out;
        got.rng  = range_error;
        got.fmt  = format_error;
        tick();
    endtask

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    task automatic test_reset();
        reset_n   = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 32'h5, 32'h13);
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        tick();
        checks++;
        if ({out_valid, instruction_out, range_error, format_error, error_count} !== 43'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b inst=%h r=%b f=%b cnt=%0d expected all 0",
                     out_valid, instruction_out, range_error, format_error, error_count);
        end
        in_valid = 1'b0;
        reset_n  = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL idle_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        drive(1'b1, 3'd1, 32'hFFFFF800, 32'h00000013);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL latency_early: got out_valid %b expected 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || instruction_out !== 32'h80000013
                || range_error !== 1'b0 || format_error !== 1'b0) begin
            errors++;
            $display("FAIL i_type: got v=%b inst=%h r=%b f=%b expected v=1 inst=80000013 r=0 f=0",
                     out_valid, instruction_out, range_error, format_error);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL consumed: got out_valid %b expected 0", out_valid);
        end
    endtask

    task automatic test_formats();
        exp_t got;
        logic seen;
        send_one(3'd3, 32'h00000FFE, 32'h00000063, got, seen);
        checks++;
        if (!seen || got.inst !== 32'h7E000FE3 || got.rng !== 1'b0 || got.fmt !== 1'b0) begin
            errors++;
            $display("FAIL b_type: got v=%b inst=%h r=%b f=%b expected v=1 inst=7E000FE3 r=0 f=0",
                     seen, got.inst, got.rng, got.fmt);
        end
        checks++;
        if (error_count !== 8'd0) begin
            errors++; $display("FAIL count_clean: got %0d expected 0", error_count);
        end
        send_one(3'd1, 32'h00000800, 32'h00000013, got, seen);
        checks++;
        if (!seen || got.inst !== 32'h80000013 || got.rng !== 1'b1 || got.fmt !== 1'b0) begin
            errors++;
            $display("FAIL i_range: got v=%b inst=%h r=%b f=%b expected v=1 inst=80000013 r=1 f=0",
                     seen, got.inst, got.rng, got.fmt);
        end
        checks++;
        if (error_count !== 8'd1) begin
            errors++; $display("FAIL count_one: got %0d expected 1", error_count);
        end
        send_one(3'd3, 32'h00000003, 32'h00000063, got, seen);
        checks++;
        if (!seen || got.rng !== 1'b1) begin
            errors++; $display("FAIL b_odd_range: got v=%b r=%b expected v=1 r=1", seen, got.rng);
        end
        send_one(3'd5, 32'hDEADBEEF, 32'h12345678, got, seen);
        checks++;
        if (!seen || got.inst !== 32'h12345678 || got.rng !== 1'b0 || got.fmt !== 1'b1) begin
            errors++;
            $display("FAIL format: got v=%b inst=%h r=%b f=%b expected v=1 inst=12345678 r=0 f=1",
                     seen, got.inst, got.rng, got.fmt);
        end
        checks++;
        if (error_count !== 8'd3) begin
            errors++; $display("FAIL count_three: got %0d expected 3", error_count);
        end
    endtask

    task automatic test_backpressure();
        logic [2:0]  sel  [3];
        logic [31:0] imm  [3];
        logic [31:0] base [3];
        exp_t        e    [3];
        int          idx;
        int          got;
        logic        fire;
        for (int k = 0; k < 3; k++) begin
            sel[k]  = 3'($urandom_range(0, 4));
            imm[k]  = $urandom;
            base[k] = $urandom;
            e[k]    = model(sel[k], imm[k], base[k]);
        end
        out_ready = 1'b0;
        idx       = 0;
        drive(1'b1, sel[0], imm[0], base[0]);
        for (int c = 0; c < 5; c++) begin
            fire = in_valid && in_ready;
            tick();
            if (fire) begin
                idx++;
                if (idx < 3) drive(1'b1, sel[idx], imm[idx], base[idx]);
                else in_valid = 1'b0;
            end
            if (c >= 1) begin
                checks++;
                if (out_valid !== 1'b1 || instruction_out !== e[0].inst
                        || range_error !== e[0].rng || format_error !== e[0].fmt) begin
                    errors++;
                    $display("FAIL bp_hold c%0d: got v=%b inst=%h r=%b f=%b expected v=1 inst=%h r=%b f=%b",
                             c, out_valid, instruction_out, range_error, format_error,
                             e[0].inst, e[0].rng, e[0].fmt);
                end
            end
        end
        checks++;
        if (idx !== 2 || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_accept: got accepted=%0d in_ready=%b expected 2 and 0", idx, in_ready);
        end
        out_ready = 1'b1;
        got       = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            if (out_valid) begin
                checks++;
                if (instruction_out !== e[got].inst || range_error !== e[got].rng
                        || format_error !== e[got].fmt) begin
                    errors++;
                    $display("FAIL bp_order %0d: got inst=%h r=%b f=%b expected inst=%h r=%b f=%b",
                             got, instruction_out, range_error, format_error,
                             e[got].inst, e[got].rng, e[got].fmt);
                end
                got++;
            end
            fire = in_valid && in_ready;
            tick();
            if (fire) begin
                idx++;
                if (idx < 3) drive(1'b1, sel[idx], imm[idx], base[idx]);
                else in_valid = 1'b0;
            end
        end
        checks++;
        if (got !== 3) begin
            errors++; $display("FAIL bp_drain: got %0d outputs expected 3", got);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_random();
        exp_t        q[$];
        exp_t        e;
        int          err_model;
        logic        stalled;
        logic [34:0] held;
        logic [31:0] imm;
        reset_n = 1'b0;
        in_valid = 1'b0;
        tick();
        reset_n   = 1'b1;
        err_model = 0;
        stalled   = 1'b0;
        held      = '0;
        for (int c = 0; c < 600; c++) begin
            if (c < 580) begin
                case ($urandom_range(0, 3))
                    0:       imm = $urandom;
                    1:       imm = 32'($signed(12'($urandom)));
                    2:       imm = 32'($signed(21'($urandom)));
                    default: imm = {20'($urandom), 12'h000};
                endcase
                drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), imm, $urandom);
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            @(negedge clk);
            checks++;
            if (error_count !== 8'(err_model)) begin
                errors++; $display("FAIL rnd_count c%0d: got %0d expected %0d", c, error_count, err_model);
            end
            if (stalled) begin
                checks++;
                if ({out_valid, instruction_out, range_error, format_error} !== held) begin
                    errors++;
                    $display("FAIL rnd_hold c%0d: got %h expected %h", c,
                             {out_valid, instruction_out, range_error, format_error}, held);
                end
            end
            stalled = out_valid && !out_ready;
            held    = {out_valid, instruction_out, range_error, format_error};
            if (in_valid && in_ready) q.push_back(model(immediate_select, immediate_value, base_fields));
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rnd_spurious c%0d: got output inst=%h expected none", c, instruction_out);
                end else begin
                    e = q.pop_front();
                    if (instruction_out !== e.inst || range_error !== e.rng || format_error !== e.fmt) begin
                        errors++;
                        $display("FAIL rnd_data c%0d: got inst=%h r=%b f=%b expected inst=%h r=%b f=%b",
                                 c, instruction_out, range_error, format_error, e.inst, e.rng, e.fmt);
                    end
                    if ((e.rng || e.fmt) && err_model < 255) err_model++;
                end
            end
            tick();
        end
        checks++;
        if (q.size() != 0) begin
            errors++; $display("FAIL rnd_drain: got %0d pending expected 0", q.size());
        end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        drive(1'b1, 3'd6, 32'h1, 32'hA5A5A5A5);
        tick();
        drive(1'b1, 3'd7, 32'h2, 32'h5A5A5A5A);
        tick();
        in_valid = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_in_ready: got %b expected 0", in_ready);
        end
        tick();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || error_count !== 8'd0) begin
            errors++; $display("FAIL midrst_flush: got v=%b cnt=%0d expected 0 0", out_valid, error_count);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL midrst_emit c%0d: got out_valid %b expected 0", c, out_valid);
            end
        end
    endtask

    task automatic test_saturation();
        int sent;
        int seen;
        out_ready = 1'b1;
        sent      = 0;
        seen      = 0;
        drive(1'b1, 3'd7, 32'h0, 32'h0);
        for (int c = 0; c < 400 && seen < 300; c++) begin
            if (out_valid) seen++;
            if (in_valid && in_ready) sent++;
            tick();
            if (sent >= 300) in_valid = 1'b0;
            if (seen == 128) begin
                checks++;
                if (error_count !== 8'd128) begin
                    errors++; $display("FAIL sat_mid: got %0d expected 128", error_count);
                end
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (seen !== 300 || error_count !== 8'd255) begin
            errors++; $display("FAIL saturate: got emitted=%0d cnt=%0d expected 300 255", seen, error_count);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        test_reset();
        test_latency();
        test_formats();
        test_backpressure();
        test_random();
        test_mid_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
